serial_sub: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 18 +
 rtl/serial_sub_full_subtractor.sv | 14 +
 rtl/serial_sub.sv | 138 +++++++++++++
 tb/tb_serial_sub.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor: FSM state encoding,
// default operand width and the bit-counter width helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;

  // Counter must reach WIDTH without wrapping.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_sub_full_subtractor.sv
// One-bit combinational full subtractor: d = a - b - bor_in, with borrow out.
// Mirror cell of the ripple adder's full_adder.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bor_in,
  output logic d,
  output logic bor_out
);

  assign d       = a ^ b ^ bor_in;
  assign bor_out = (~a & b) | (~(a ^ b) & bor_in);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor (diff = a - b - b_in), LSB first, one bit per clock.
// Optional signed-overflow output is enabled with `define SERIAL_SUB_OVF_EN.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             done
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bor_q, bor_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             fs_d, fs_bor;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  full_subtractor u_fs (
    .a      (a_sh_q[0]),
    .b      (b_sh_q[0]),
    .bor_in (bor_q),
    .d      (fs_d),
    .bor_out(fs_bor)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    bor_d   = bor_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          bor_d   = b_in;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = {fs_d, res_q[WIDTH-1:1]};
        bor_d  = fs_bor;
        cnt_d  = cnt_q + CW'(1);
        // Visible outputs are only refreshed on the final bit, never mid-operation.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          diff_d  = {fs_d, res_q[WIDTH-1:1]};
          bout_d  = fs_bor;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (a_msb_q ^ b_msb_q) & (fs_d ^ a_msb_q);
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      bor_q   <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      bor_q   <= bor_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = (state_q == DONE);
  assign diff  = diff_q;
  assign b_out = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=4) against an arithmetic reference model.
// Also covers the ovf output when built with SERIAL_SUB_OVF_EN.
module tb_serial_sub;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic         ready;
  logic [W-1:0] diff;
  logic         b_out;
  logic         done;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] last_diff;

  serial_sub #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .b_in (b_in),
    .ready(ready),
    .diff (diff),
    .b_out(b_out),
`ifdef SERIAL_SUB_OVF_EN
    .ovf  (ovf),
`endif
    .done (done)
  );

  always #5 clk = ~clk;

  // Reference model: plain unsigned / signed arithmetic.
  function automatic logic [W-1:0] m_diff(input int x, input int y, input int bi);
    int r;
    r = (x - y - bi) % (1 << W);
    if (r < 0) r += (1 << W);
    return r[W-1:0];
  endfunction

  function automatic logic m_bout(input int x, input int y, input int bi);
    return (x < y + bi);
  endfunction

  function automatic logic m_ovf(input int x, input int y, input int bi);
    int sx, sy, r;
    sx = (x >= (1 << (W-1))) ? x - (1 << W) : x;
    sy = (y >= (1 << (W-1))) ? y - (1 << W) : y;
    r  = sx - sy - bi;
    return (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
  endfunction

  // Drive one request through acceptance; scramble operands afterwards.
  task automatic launch(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic bi);
    @(negedge clk);
    start = 1'b1; a = aa; b = bb; b_in = bi;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
  endtask

  // Count negedges until done (n=-1 on timeout); flag any diff change before done.
  task automatic wait_done(input int limit, input logic [W-1:0] hold_val,
                           output int n, output logic moved);
    n = -1; moved = 1'b0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n = i;
        break;
      end
      if (diff !== hold_val) moved = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || diff !== '0 || b_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got ready=%b done=%b diff=%h b_out=%b exp 1 0 0 0", ready, done, diff, b_out);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf got=%b exp=0", ovf);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got ready=%b done=%b exp 1 0", ready, done);
    end
    last_diff = '0;
  endtask

  task automatic test_subtract;
    logic [W-1:0] ta[3] = '{4'd9, 4'd3, 4'd0};
    logic [W-1:0] tb[3] = '{4'd3, 4'd9, 4'd0};
    logic         ti[3] = '{1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 11; k++) begin
      logic [W-1:0] xa, xb, ed;
      logic xi, eb, moved;
      int n;
      if (k < 3) begin
        xa = ta[k]; xb = tb[k]; xi = ti[k];
      end else begin
        xa = W'($urandom); xb = W'($urandom); xi = 1'($urandom);
      end
      ed = m_diff(int'(xa), int'(xb), int'(xi));
      eb = m_bout(int'(xa), int'(xb), int'(xi));
      launch(xa, xb, xi);
      wait_done(20, last_diff, n, moved);
      checks++;
      if (n != W + 1) begin
        errors++;
        $display("FAIL sub_latency op%0d got=%0d exp=%0d", k, n, W + 1);
      end
      checks++;
      if (moved !== 1'b0) begin
        errors++;
        $display("FAIL sub_hold op%0d diff moved before done, exp held %h", k, last_diff);
      end
      checks++;
      if (diff !== ed || b_out !== eb) begin
        errors++;
        $display("FAIL sub_result %0d-%0d-%0d got diff=%h b_out=%b exp diff=%h b_out=%b",
                 xa, xb, xi, diff, b_out, ed, eb);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || ready !== 1'b1 || diff !== ed) begin
        errors++;
        $display("FAIL sub_after op%0d got done=%b ready=%b diff=%h exp 0 1 %h", k, done, ready, diff, ed);
      end
      last_diff = ed;
    end
  endtask

  task automatic test_ignore_start;
    int n, extra;
    logic moved;
    launch(4'd9, 4'd3, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL ign_ready got=%b exp=0", ready);
    end
    start = 1'b1; a = 4'd1; b = 4'd7; b_in = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(20, last_diff, n, moved);
    checks++;
    if (n != W - 1) begin
      errors++;
      $display("FAIL ign_latency got=%0d exp=%0d", n, W - 1);
    end
    checks++;
    if (diff !== 4'd6 || b_out !== 1'b0) begin
      errors++;
      $display("FAIL ign_result got diff=%h b_out=%b exp diff=6 b_out=0", diff, b_out);
    end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL ign_extra_done got=%0d exp=0", extra);
    end
    last_diff = 4'd6;
  endtask

  task automatic test_reset_mid;
    int n, extra;
    logic moved;
    launch(4'd12, 4'd5, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || diff !== '0 || b_out !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got ready=%b done=%b diff=%h b_out=%b exp 1 0 0 0", ready, done, diff, b_out);
    end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL abort_done got=%0d exp=0", extra);
    end
    last_diff = '0;
    launch(4'd7, 4'd2, 1'b0);
    wait_done(20, last_diff, n, moved);
    checks++;
    if (n != W + 1 || diff !== 4'd5 || b_out !== 1'b0) begin
      errors++;
      $display("FAIL abort_fresh got n=%0d diff=%h b_out=%b exp n=%0d diff=5 b_out=0", n, diff, b_out, W + 1);
    end
    last_diff = 4'd5;
  endtask

  task automatic test_back_to_back;
    int ndone, prev, bad_gap, bad_val;
    @(negedge clk);
    start = 1'b1; a = 4'd15; b = 4'd1; b_in = 1'b0;
    ndone = 0; prev = 0; bad_gap = 0; bad_val = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (prev != 0 && i - prev != W + 2) bad_gap++;
        prev = i;
        if (diff !== 4'd14 || b_out !== 1'b0) bad_val++;
      end else if (ndone > 0) begin
        if (diff !== 4'd14) bad_val++;
      end else if (diff !== last_diff) begin
        bad_val++;
      end
    end
    start = 1'b0;
    checks++;
    if (ndone != 5) begin
      errors++;
      $display("FAIL b2b_count got=%0d exp=5", ndone);
    end
    checks++;
    if (bad_gap != 0) begin
      errors++;
      $display("FAIL b2b_period got %0d bad gaps exp 0 (period %0d)", bad_gap, W + 2);
    end
    checks++;
    if (bad_val != 0) begin
      errors++;
      $display("FAIL b2b_value got %0d bad samples exp 0", bad_val);
    end
    last_diff = 4'd14;
    repeat (2) @(negedge clk);
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf;
    logic [W-1:0] ta[2] = '{4'd8, 4'd5};
    logic [W-1:0] tb[2] = '{4'd1, 4'd3};
    for (int k = 0; k < 8; k++) begin
      logic [W-1:0] xa, xb, ed;
      logic xi, eo, moved;
      int n;
      if (k < 2) begin
        xa = ta[k]; xb = tb[k]; xi = 1'b0;
      end else begin
        xa = W'($urandom); xb = W'($urandom); xi = 1'($urandom);
      end
      ed = m_diff(int'(xa), int'(xb), int'(xi));
      eo = m_ovf(int'(xa), int'(xb), int'(xi));
      launch(xa, xb, xi);
      wait_done(20, last_diff, n, moved);
      checks++;
      if (n != W + 1 || diff !== ed || ovf !== eo) begin
        errors++;
        $display("FAIL ovf %0d-%0d-%0d got n=%0d diff=%h ovf=%b exp n=%0d diff=%h ovf=%b",
                 xa, xb, xi, n, diff, ovf, W + 1, ed, eo);
      end
      last_diff = ed;
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_subtract();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
